translate_reader: RTL and testbench

Frame-readback engine for the geometric transform path. It reads a stored WIDTH×HEIGHT 8-bit image from a synchronous frame memory, applies a translation by (offset_x, offset_y), and emits the translated image as a raster-order pixel stream under valid/ready flow control. Source pixels that fall outside the stored frame are replaced by a fill value. It sits between the frame buffer written by the capture/transform stage and the downstream display/compare stage.

---
 rtl/translate_reader.sv | 182 ++++++++++++++++++
 tb/tb_translate_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/translate_reader.sv
// Frame-readback engine: reads a stored frame, shifts it by (offset_x, offset_y) and streams
// it out in raster order under valid/ready; sources outside the frame are replaced by FILL.
module translate_reader #(
  parameter int         WIDTH  = 64,
  parameter int         HEIGHT = 64,
  parameter logic [7:0] FILL   = 8'h00,
  parameter int         ADDR_W = $clog2(WIDTH*HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        offset_x,
  input  logic [7:0]        offset_y,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        pixel_out,
  output logic              pixel_valid,
  input  logic              pixel_ready
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  // Wide enough that no coordinate/offset combination can wrap back into the frame.
  localparam int CW = ((XW > YW) ? XW : YW) + 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [7:0]          ox_q, ox_d;
  logic [7:0]          oy_q, oy_d;
  logic                in_range_q, in_range_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          pix_q, pix_d;
  logic                valid_q, valid_d;

  logic [XW-1:0]       nx;
  logic [YW-1:0]       ny;
  logic [7:0]          nox, noy;
  logic [CW-1:0]       sx, sy;
  logic                n_in_range;
  logic                go_fetch;
  logic                last_px;

  assign last_px = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));

  // Next-state logic; the read strobe and address are prepared for the pixel about to be fetched.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    in_range_d = in_range_q;
    busy_d     = busy_q;
    done_d     = done_q;
    rd_en_d    = rd_en_q;
    addr_d     = addr_q;
    pix_d      = pix_q;
    valid_d    = valid_q;
    nx         = x_q;
    ny         = y_q;
    nox        = ox_q;
    noy        = oy_q;
    go_fetch   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nox      = offset_x;
          noy      = offset_y;
          nx       = '0;
          ny       = '0;
          ox_d     = offset_x;
          oy_d     = offset_y;
          x_d      = '0;
          y_d      = '0;
          busy_d   = 1'b1;
          go_fetch = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        rd_en_d = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        pix_d   = in_range_q ? mem_data : FILL;
        valid_d = 1'b1;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (pixel_ready) begin
          valid_d = 1'b0;
          if (last_px) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            if (x_q == XW'(WIDTH - 1)) begin
              nx = '0;
              ny = y_q + 1'b1;
            end else begin
              nx = x_q + 1'b1;
            end
            x_d      = nx;
            y_d      = ny;
            go_fetch = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    sx = {{(CW-XW){1'b0}}, nx} - {{(CW-8){nox[7]}}, nox};
    sy = {{(CW-YW){1'b0}}, ny} - {{(CW-8){noy[7]}}, noy};
    // Negative sources look huge when compared unsigned, so one compare per axis suffices.
    n_in_range = (sx < CW'(WIDTH)) && (sy < CW'(HEIGHT));

    if (go_fetch) begin
      in_range_d = n_in_range;
      rd_en_d    = n_in_range;
      addr_d     = n_in_range ? ADDR_W'({sy[YW-1:0], sx[XW-1:0]}) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      in_range_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      pix_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      in_range_q <= in_range_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      pix_q      <= pix_d;
      valid_q    <= valid_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_addr    = addr_q;
  assign pixel_out   = pix_q;
  assign pixel_valid = valid_q;

endmodule

// File: tb/tb_translate_reader.sv
// Scoreboard bench for translate_reader: a reference model fills an expected-pixel queue per
// frame and a negedge monitor pops and compares on every pixel handshake.
module tb_translate_reader;

  localparam int W = 64;
  localparam int H = 64;
  localparam int N = W * H;
  localparam logic [7:0] FILL = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  offset_x, offset_y;
  logic        busy, done, mem_rd_en;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  pixel_out;
  logic        pixel_valid;
  logic        pixel_ready;

  logic [7:0]  mem [N];
  logic [7:0]  got [N];
  logic [7:0]  exp_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int hs_count    = 0;
  int rd_count    = 0;
  int done_count  = 0;
  int ready_mode  = 0;
  int stall       = 0;
  bit stalled_once = 1'b0;

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_rd    = 1'b0;
  logic [7:0] prev_pix   = '0;
  logic [11:0] prev_addr = '0;

  translate_reader #(.WIDTH(W), .HEIGHT(H), .FILL(FILL), .ADDR_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .offset_x   (offset_x),
    .offset_y   (offset_y),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .pixel_out  (pixel_out),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready)
  );

  always #5 clk = ~clk;

  // Synchronous frame memory; garbage on idle cycles so unread data is never trusted.
  always @(posedge clk) mem_data <= mem_rd_en ? mem[mem_addr] : 8'($urandom);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic buildExpected(input int ox, input int oy, output int reads);
    reads = 0;
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int sx, sy;
        sx = x - ox;
        sy = y - oy;
        if (sx >= 0 && sx < W && sy >= 0 && sy < H) begin
          exp_q.push_back(mem[sy*W + sx]);
          reads++;
        end else begin
          exp_q.push_back(FILL);
        end
      end
  endtask

  // Ready driver: always high, or random with one forced 5-cycle stall while a pixel is shown.
  initial begin
    pixel_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        pixel_ready = 1'b1;
      end else begin
        if (!stalled_once && pixel_valid && hs_count == 50) begin
          stalled_once = 1'b1;
          stall = 5;
        end
        if (stall > 0) begin
          pixel_ready = 1'b0;
          stall--;
        end else begin
          pixel_ready = ($urandom_range(0, 3) != 0);
        end
      end
    end
  end

  // Monitor: scoreboard pops, stall-hold rules and read/done bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_rd    = 1'b0;
      end else begin
        if (mem_rd_en) begin
          rd_count++;
          checkOutput("rd_single_cycle", {31'd0, prev_rd}, 32'd0);
        end
        if (prev_valid && !prev_ready) begin
          checkOutput("hold_valid", {31'd0, pixel_valid}, 32'd1);
          checkOutput("hold_pixel", {24'd0, pixel_out}, {24'd0, prev_pix});
          checkOutput("hold_no_read", {31'd0, mem_rd_en}, 32'd0);
          checkOutput("hold_addr", {20'd0, mem_addr}, {20'd0, prev_addr});
        end
        if (pixel_valid && pixel_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL pixel_extra: got %0h, expected no pixel", pixel_out);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checkOutput($sformatf("pixel[%0d]", hs_count), {24'd0, pixel_out}, {24'd0, e});
          end
          if (hs_count < N) got[hs_count] = pixel_out;
          hs_count++;
        end
        if (done) done_count++;
        prev_valid = pixel_valid;
        prev_ready = pixel_ready;
        prev_rd    = mem_rd_en;
        prev_pix   = pixel_out;
        prev_addr  = mem_addr;
      end
    end
  end

  task automatic applyStimulus(input int ox, input int oy, input int mode, input bit second_start);
    int reads, n, limit;
    buildExpected(ox, oy, reads);
    ready_mode   = mode;
    stalled_once = 1'b0;
    stall        = 0;
    hs_count     = 0;
    rd_count     = 0;
    done_count   = 0;
    limit        = (mode == 0) ? 13000 : 24000;
    @(negedge clk);
    offset_x = 8'(ox);
    offset_y = 8'(oy);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    checkOutput("busy_rise", {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && n < limit) begin
      @(posedge clk);
      n++;
      #1;
      offset_x = 8'($urandom);
      offset_y = 8'($urandom);
      start = (second_start && n == 10);
      if (n == 2) checkOutput("latency_not_yet", {31'd0, pixel_valid}, 32'd0);
      if (n == 3) checkOutput("latency_first", {31'd0, pixel_valid}, 32'd1);
    end
    start = 1'b0;
    checkOutput("done_seen", {31'd0, done}, 32'd1);
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    if (mode == 0) checkOutput("done_cycle", n, 3*N + 1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("done_pulse_count", done_count, 1);
    checkOutput("pixel_count", hs_count, N);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("read_count", rd_count, reads);
    checkOutput("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int bad, reads, aox, aoy;
    rst = 1'b1;
    start = 1'b0;
    offset_x = '0;
    offset_y = '0;
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_rd_en", {31'd0, mem_rd_en}, 32'd0);
    checkOutput("reset_addr", {20'd0, mem_addr}, 32'd0);
    checkOutput("reset_valid", {31'd0, pixel_valid}, 32'd0);
    checkOutput("reset_pixel", {24'd0, pixel_out}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] frame offsets (0,0), ramp memory");
    for (int a = 0; a < N; a++) mem[a] = 8'(a);
    applyStimulus(0, 0, 0, 1'b0);
    bad = 0;
    for (int k = 0; k < N; k++) if (got[k] !== 8'(k)) bad++;
    checkOutput("ramp_stream", bad, 0);

    $display("[TB] frame offsets (10,5), random memory, backpressure");
    for (int a = 0; a < N; a++) mem[a] = 8'($urandom_range(1, 255));
    applyStimulus(10, 5, 1, 1'b0);
    checkOutput("p00_fill", {24'd0, got[0]}, {24'd0, FILL});
    checkOutput("p9_5_fill", {24'd0, got[5*W + 9]}, {24'd0, FILL});
    checkOutput("p10_4_fill", {24'd0, got[4*W + 10]}, {24'd0, FILL});
    checkOutput("p10_5", {24'd0, got[5*W + 10]}, {24'd0, mem[0]});
    checkOutput("p63_63", {24'd0, got[63*W + 63]}, {24'd0, mem[58*W + 53]});
    checkOutput("reads_10_5", rd_count, 54*59);

    $display("[TB] frame offsets (-3,0)");
    for (int a = 0; a < N; a++) mem[a] = 8'($urandom_range(1, 255));
    applyStimulus(-3, 0, 0, 1'b0);
    checkOutput("m3_p0", {24'd0, got[0]}, {24'd0, mem[3]});
    checkOutput("m3_p60", {24'd0, got[60]}, {24'd0, mem[63]});
    bad = 0;
    for (int y = 0; y < H; y++)
      for (int x = 61; x < W; x++) if (got[y*W + x] !== FILL) bad++;
    checkOutput("m3_right_fill", bad, 0);

    $display("[TB] frame offsets (64,0) with a second start while busy");
    applyStimulus(64, 0, 0, 1'b1);
    bad = 0;
    for (int k = 0; k < N; k++) if (got[k] !== FILL) bad++;
    checkOutput("all_fill", bad, 0);
    checkOutput("all_fill_reads", rd_count, 0);

    $display("[TB] reset at pixel 100");
    aox = $urandom_range(0, 8) - 4;
    aoy = $urandom_range(0, 8) - 4;
    buildExpected(aox, aoy, reads);
    ready_mode = 0;
    hs_count   = 0;
    rd_count   = 0;
    done_count = 0;
    @(negedge clk);
    offset_x = 8'(aox);
    offset_y = 8'(aoy);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (hs_count == 100 && pixel_valid) break;
      @(posedge clk);
      #1;
    end
    checkOutput("abort_reached", hs_count, 100);
    rst = 1'b1;
    #1;
    checkOutput("abort_valid", {31'd0, pixel_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_rd_en", {31'd0, mem_rd_en}, 32'd0);
    checkOutput("abort_pixel", {24'd0, pixel_out}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abort_no_done", done_count, 0);
    checkOutput("abort_idle", {30'd0, busy, pixel_valid}, 32'd0);

    $display("[TB] fresh frame after reset");
    for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
    applyStimulus($urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
